// File: rtl/pc_redirect_controller.sv
// pc_redirect_controller: owns the fetch PC, selects PC+4 / J / JR / branch targets and squashes wrong-path IF slots.
// Optional define DELAY_SLOT_EN keeps the first post-redirect fetch (branch delay slot) alive.
module pc_redirect_controller #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        DecodeValid,
  input  logic [31:0] Instruction,
  input  logic [31:0] DecodePCPlus4,
  input  logic        Jump,
  input  logic        JumpReg,
  input  logic [31:0] RegTarget,
  input  logic        Branch,
  input  logic        BranchTaken,
  input  logic [31:0] BranchOffset,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        FlushIF,
  output logic [1:0]  State,
  output logic [15:0] RedirectCount
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1
  } state_t;

`ifdef DELAY_SLOT_EN
  localparam int FLUSH_LEN = FLUSH_CYCLES - 1;
`else
  localparam int FLUSH_LEN = FLUSH_CYCLES;
`endif
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_LEN);

  state_t      fsm_state;
  logic [2:0]  flush_cnt;
  logic        redir;
  logic [31:0] target;
  logic        unused_bits;

  assign unused_bits = &{1'b0, Instruction[31:26], RegTarget[1:0], BranchOffset[31:30]};

  // Requests arriving while squashing belong to the wrong path and are dropped.
  assign redir   = DecodeValid && (fsm_state == RUN) && (JumpReg || Jump || (Branch && BranchTaken));
  assign PCPlus4 = PC + 32'd4;
  assign State   = fsm_state;

  always_comb begin
    target = DecodePCPlus4 + {BranchOffset[29:0], 2'b00};
    if (JumpReg) begin
      target = {RegTarget[31:2], 2'b00};
    end else if (Jump) begin
      target = {DecodePCPlus4[31:28], Instruction[25:0], 2'b00};
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      PC            <= RESET_PC;
      FlushIF       <= 1'b0;
      fsm_state     <= RUN;
      flush_cnt     <= 3'd0;
      RedirectCount <= 16'd0;
    end else if (!Stall) begin
      case (fsm_state)
        RUN: begin
          if (redir) begin
            PC <= target;
            if (RedirectCount != 16'hFFFF) begin
              RedirectCount <= RedirectCount + 16'd1;
            end
            // A zero-length squash (delay slot with one flush cycle) never leaves RUN.
            if (FLUSH_INIT != 3'd0) begin
              fsm_state <= FLUSH;
              flush_cnt <= FLUSH_INIT;
              FlushIF   <= 1'b1;
            end
          end else begin
            PC <= PCPlus4;
          end
        end
        FLUSH: begin
          PC        <= PCPlus4;
          flush_cnt <= flush_cnt - 3'd1;
          if (flush_cnt == 3'd1) begin
            fsm_state <= RUN;
            FlushIF   <= 1'b0;
          end
        end
        default: begin
          fsm_state <= RUN;
          flush_cnt <= 3'd0;
          FlushIF   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_redirect_controller.sv
// Testbench for pc_redirect_controller: two instances (FLUSH_CYCLES 1 and 3) checked against a spec-level model.
// Honours DELAY_SLOT_EN the same way the design does.
module tb_pc_redirect_controller;

`ifdef DELAY_SLOT_EN
  localparam int DLY = 1;
`else
  localparam int DLY = 0;
`endif
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int LEN1 = 1 - DLY;
  localparam int LEN3 = 3 - DLY;
  localparam int NV   = 8;

  typedef struct {
    logic        dv, j, jr, br, bt;
    logic [31:0] instr, pc4, rt, off;
    logic        redir;
    logic [31:0] expPc;
  } vec_t;

  logic        Clk = 1'b0;
  logic        Rst, Stall, DecodeValid, Jump, JumpReg, Branch, BranchTaken;
  logic [31:0] Instruction, DecodePCPlus4, RegTarget, BranchOffset;
  logic [31:0] pcA, pcp4A, pcB, pcp4B;
  logic        flushA, flushB;
  logic [1:0]  stateA, stateB;
  logic [15:0] countA, countB;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mPc [2];
  int          mLeft [2];
  int          mCnt [2];
  int          lens [2] = '{LEN1, LEN3};
  vec_t        vecs [NV];

  pc_redirect_controller #(.RESET_PC(RST_PC), .FLUSH_CYCLES(1)) dutA (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .DecodeValid(DecodeValid), .Instruction(Instruction),
    .DecodePCPlus4(DecodePCPlus4), .Jump(Jump), .JumpReg(JumpReg), .RegTarget(RegTarget),
    .Branch(Branch), .BranchTaken(BranchTaken), .BranchOffset(BranchOffset),
    .PC(pcA), .PCPlus4(pcp4A), .FlushIF(flushA), .State(stateA), .RedirectCount(countA));

  pc_redirect_controller #(.RESET_PC(RST_PC), .FLUSH_CYCLES(3)) dutB (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .DecodeValid(DecodeValid), .Instruction(Instruction),
    .DecodePCPlus4(DecodePCPlus4), .Jump(Jump), .JumpReg(JumpReg), .RegTarget(RegTarget),
    .Branch(Branch), .BranchTaken(BranchTaken), .BranchOffset(BranchOffset),
    .PC(pcB), .PCPlus4(pcp4B), .FlushIF(flushB), .State(stateB), .RedirectCount(countB));

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic vec_t mkVec(input logic dv, j, jr, br, bt, input logic [31:0] instr, pc4, rt, off,
                                 input logic redir, input logic [31:0] expPc);
    vec_t v;
    v.dv = dv; v.j = j; v.jr = jr; v.br = br; v.bt = bt;
    v.instr = instr; v.pc4 = pc4; v.rt = rt; v.off = off;
    v.redir = redir; v.expPc = expPc;
    return v;
  endfunction

  // Target rules written directly as arithmetic on the decode fields.
  function automatic logic [31:0] refTarget();
    if (JumpReg) return RegTarget & 32'hFFFF_FFFC;
    if (Jump) return (DecodePCPlus4 & 32'hF000_0000) | ((Instruction & 32'h03FF_FFFF) << 2);
    return DecodePCPlus4 + BranchOffset * 32'd4;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mPc[i] = RST_PC;
      mLeft[i] = 0;
      mCnt[i] = 0;
    end
  endtask

  task automatic modelStep();
    for (int i = 0; i < 2; i++) begin
      if (!Rst) begin
        mPc[i] = RST_PC; mLeft[i] = 0; mCnt[i] = 0;
      end else if (!Stall) begin
        if (mLeft[i] > 0) begin
          mPc[i] = mPc[i] + 32'd4;
          mLeft[i]--;
        end else if (DecodeValid && (JumpReg || Jump || (Branch && BranchTaken))) begin
          mPc[i] = refTarget();
          mCnt[i] = (mCnt[i] >= 65535) ? 65535 : mCnt[i] + 1;
          mLeft[i] = lens[i];
        end else begin
          mPc[i] = mPc[i] + 32'd4;
        end
      end
    end
  endtask

  task automatic checkOutput();
    check("pcA", pcA, mPc[0]);
    check("pcPlus4A", pcp4A, mPc[0] + 32'd4);
    check("flushA", 32'(flushA), 32'(mLeft[0] > 0));
    check("stateA", 32'(stateA), 32'(mLeft[0] > 0));
    check("countA", 32'(countA), 32'(mCnt[0]));
    check("pcB", pcB, mPc[1]);
    check("pcPlus4B", pcp4B, mPc[1] + 32'd4);
    check("flushB", 32'(flushB), 32'(mLeft[1] > 0));
    check("stateB", 32'(stateB), 32'(mLeft[1] > 0));
    check("countB", 32'(countB), 32'(mCnt[1]));
  endtask

  task automatic cycle();
    @(posedge Clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic clearInputs();
    Stall = 1'b0; DecodeValid = 1'b0; Jump = 1'b0; JumpReg = 1'b0; Branch = 1'b0; BranchTaken = 1'b0;
    Instruction = 32'd0; DecodePCPlus4 = 32'd0; RegTarget = 32'd0; BranchOffset = 32'd0;
  endtask

  task automatic applyStimulus(input vec_t v);
    Stall = 1'b0;
    DecodeValid = v.dv; Jump = v.j; JumpReg = v.jr; Branch = v.br; BranchTaken = v.bt;
    Instruction = v.instr; DecodePCPlus4 = v.pc4; RegTarget = v.rt; BranchOffset = v.off;
  endtask

  initial begin
    logic [31:0] expPc;
    logic [31:0] pcHold;
    int          cntBefore;
    int          flushSeen;
    int          done;
    logic [31:0] r;

    vecs[0] = mkVec(1, 1, 0, 0, 0, 32'h0800_0040, 32'h4000_0010, 32'h0, 32'h0, 1, 32'h4000_0100);
    vecs[1] = mkVec(1, 1, 1, 0, 0, 32'h0800_0040, 32'h4000_0010, 32'h0000_1237, 32'h0, 1, 32'h0000_1234);
    vecs[2] = mkVec(1, 0, 0, 1, 1, 32'h0, 32'hFFFF_FFF0, 32'h0, 32'h0000_0008, 1, 32'h0000_0010);
    vecs[3] = mkVec(1, 0, 0, 1, 0, 32'h0, 32'hFFFF_FFF0, 32'h0, 32'h0000_0008, 0, 32'h0);
    vecs[4] = mkVec(1, 0, 0, 1, 1, 32'h0, 32'h0000_1000, 32'h0, 32'hFFFF_FFFF, 1, 32'h0000_0FFC);
    vecs[5] = mkVec(0, 1, 0, 0, 0, 32'h0800_0040, 32'h4000_0010, 32'h0, 32'h0, 0, 32'h0);
    vecs[6] = mkVec(1, 0, 1, 0, 0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 1, 32'hFFFF_FFFC);
    vecs[7] = mkVec(1, 1, 0, 1, 1, 32'h0800_0040, 32'h4000_0010, 32'h0, 32'h0000_0008, 1, 32'h4000_0100);

    // Reset held for three edges, then sequential fetch.
    clearInputs();
    Rst = 1'b0;
    modelReset();
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("resetPcA", pcA, RST_PC);
      check("resetFlushB", 32'(flushB), 32'd0);
    end
    Rst = 1'b1;
    #1;
    check("releasePcA", pcA, 32'h0000_0000);
    for (int k = 1; k <= 3; k++) begin
      cycle();
      check($sformatf("seqPcA_%0d", k), pcA, 32'(k * 4));
      check($sformatf("seqCountA_%0d", k), 32'(countA), 32'd0);
    end

    $display("[TB] table vectors");
    for (int v = 0; v < NV; v++) begin
      clearInputs();
      repeat (4) cycle();
      applyStimulus(vecs[v]);
      expPc = vecs[v].redir ? vecs[v].expPc : mPc[0] + 32'd4;
      cntBefore = mCnt[0];
      cycle();
      check($sformatf("vec%0d_pcA", v), pcA, expPc);
      check($sformatf("vec%0d_pcB", v), pcB, expPc);
      check($sformatf("vec%0d_flushA", v), 32'(flushA), 32'(vecs[v].redir && (LEN1 > 0)));
      check($sformatf("vec%0d_flushB", v), 32'(flushB), 32'(vecs[v].redir));
      check($sformatf("vec%0d_countA", v), 32'(countA), 32'(cntBefore + int'(vecs[v].redir)));
    end

    $display("[TB] stalled redirect");
    clearInputs();
    repeat (4) cycle();
    pcHold = mPc[0];
    applyStimulus(vecs[0]);
    Stall = 1'b1;
    repeat (2) begin
      cycle();
      check("stallPcA", pcA, pcHold);
      check("stallFlushA", 32'(flushA), 32'd0);
      check("stallFlushB", 32'(flushB), 32'd0);
    end
    Stall = 1'b0;
    cycle();
    check("stallRedirPcB", pcB, 32'h4000_0100);
    check("stallRedirFlushB", 32'(flushB), 32'd1);
    clearInputs();
    flushSeen = 0;
    done = 0;
    for (int k = 0; k < 40 && done == 0; k++) begin
      Stall = (k % 2 == 1);
      if (flushB && !Stall) flushSeen++;
      cycle();
      if (!flushB) done = 1;
    end
    Stall = 1'b0;
    check("flushEndB", 32'(done), 32'd1);
    check("flushLenB", 32'(flushSeen), 32'(LEN3));

    $display("[TB] reset during flush");
    clearInputs();
    repeat (4) cycle();
    applyStimulus(vecs[0]);
    cycle();
    clearInputs();
    cycle();
    check("midFlushB", 32'(flushB), 32'd1);
    #2;
    Rst = 1'b0;
    #1;
    modelReset();
    check("asyncRstPcB", pcB, RST_PC);
    check("asyncRstFlushB", 32'(flushB), 32'd0);
    check("asyncRstStateB", 32'(stateB), 32'd0);
    check("asyncRstCountB", 32'(countB), 32'd0);
    checkOutput();
    cycle();
    Rst = 1'b1;
    cycle();
    check("postRstPcA", pcA, RST_PC + 32'd4);

    $display("[TB] random stimulus");
    for (int k = 0; k < 400; k++) begin
      Stall = ($urandom_range(0, 4) == 0);
      DecodeValid = ($urandom_range(0, 3) != 0);
      Jump = ($urandom_range(0, 5) == 0);
      JumpReg = ($urandom_range(0, 7) == 0);
      Branch = ($urandom_range(0, 3) == 0);
      BranchTaken = 1'($urandom_range(0, 1));
      Instruction = $urandom();
      DecodePCPlus4 = $urandom();
      RegTarget = $urandom();
      r = $urandom();
      BranchOffset = {{16{r[15]}}, r[15:0]};
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
